// File: rtl/gt_reset_pkg.sv
// Shared types and constants for the transceiver reset controller.
package gt_reset_pkg;

   localparam int unsigned SYNC_STAGES = 5;
   localparam int unsigned RETRY_W     = 3;

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      GT_RESET  = 3'd2,
      WAIT_DONE = 3'd3,
      READY     = 3'd4,
      FAILED    = 3'd5
   } state_e;

   typedef logic [RETRY_W-1:0] retry_t;

   // Saturating increment so the count sticks at its maximum.
   function automatic retry_t retry_inc(input retry_t r);
      return (r == '1) ? r : r + retry_t'(1);
   endfunction

endpackage

// File: rtl/gt_reset_controller_if.sv
// Control/status bundle between board reset logic, the controller and the transceiver wrapper.
interface gt_reset_controller_if;
   import gt_reset_pkg::*;

   logic   start_in;
   logic   pll_lock_in;
   logic   gt_reset_done_in;
   logic   pll_reset_out;
   logic   gt_reset_out;
   logic   user_ready_out;
   logic   error_out;
   retry_t retry_count_out;

   modport master (
      input  start_in, pll_lock_in, gt_reset_done_in,
      output pll_reset_out, gt_reset_out, user_ready_out, error_out, retry_count_out
   );

   modport slave (
      output start_in, pll_lock_in, gt_reset_done_in,
      input  pll_reset_out, gt_reset_out, user_ready_out, error_out, retry_count_out
   );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level; deliberately has no reset.
module bit_synchronizer #(
   parameter int unsigned STAGES     = 5,
   parameter logic        INITIALIZE = 1'b0
) (
   input  logic clk_in,
   input  logic data_in,
   output logic data_out
);

   logic [STAGES-1:0] sync_q = {STAGES{INITIALIZE}};
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], data_in};
   end

   always_ff @(posedge clk_in) begin
      sync_q <= sync_d;
   end

   assign data_out = sync_q[STAGES-1];

endmodule

// File: rtl/gt_reset_controller.sv
// Sequences PLL and channel reset of a transceiver, waits for lock/done, retries on timeouts,
// and flags a terminal failure once the retry budget is spent.
module gt_reset_controller
   import gt_reset_pkg::*;
#(
   parameter int unsigned PLL_RESET_CYCLES    = 16,
   parameter int unsigned GT_RESET_CYCLES     = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
   parameter int unsigned DONE_TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   gt_reset_controller_if.master bus
);

   localparam int unsigned MAX_AB  = (PLL_RESET_CYCLES > GT_RESET_CYCLES) ?
                                     PLL_RESET_CYCLES : GT_RESET_CYCLES;
   localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > DONE_TIMEOUT_CYCLES) ?
                                     LOCK_TIMEOUT_CYCLES : DONE_TIMEOUT_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] GT_LAST   = CNT_W'(GT_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT_CYCLES - 1);
   localparam retry_t           RETRY_LIM = RETRY_W'(MAX_RETRIES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   retry_t           retry_q, retry_d;
   retry_t           retry_nxt;
   logic             pll_reset_q, pll_reset_d;
   logic             gt_reset_q, gt_reset_d;
   logic             ready_q, ready_d;
   logic             error_q, error_d;
   logic             lock_s, done_s;

   bit_synchronizer #(.STAGES(SYNC_STAGES), .INITIALIZE(1'b0)) u_lock_sync (
      .clk_in   (clk_in),
      .data_in  (bus.pll_lock_in),
      .data_out (lock_s)
   );

   bit_synchronizer #(.STAGES(SYNC_STAGES), .INITIALIZE(1'b0)) u_done_sync (
      .clk_in   (clk_in),
      .data_in  (bus.gt_reset_done_in),
      .data_out (done_s)
   );

   // Next state: start > lock loss > done loss/seen > timeout.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retry_d   = retry_q;
      retry_nxt = retry_inc(retry_q);

      if (bus.start_in) begin
         state_d = PLL_RESET;
         retry_d = '0;
      end else begin
         case (state_q)
            PLL_RESET: begin
               if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = GT_RESET;
               end else if (cnt_q == LOCK_LAST) begin
                  retry_d = retry_nxt;
                  state_d = (retry_nxt >= RETRY_LIM) ? FAILED : PLL_RESET;
               end
            end
            GT_RESET: begin
               if (!lock_s)               state_d = PLL_RESET;
               else if (cnt_q == GT_LAST) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
               if (!lock_s) begin
                  state_d = PLL_RESET;
               end else if (done_s) begin
                  state_d = READY;
               end else if (cnt_q == DONE_LAST) begin
                  retry_d = retry_nxt;
                  state_d = (retry_nxt >= RETRY_LIM) ? FAILED : GT_RESET;
               end
            end
            READY: begin
               if (!lock_s)      state_d = PLL_RESET;
               else if (!done_s) state_d = GT_RESET;
            end
            FAILED:  state_d = FAILED;
            default: state_d = PLL_RESET;
         endcase
      end

      // Counter restarts on every entry (a start re-enters PLL_RESET even from PLL_RESET).
      if (bus.start_in || (state_d != state_q)) begin
         cnt_d = '0;
      end else if ((state_q != READY) && (state_q != FAILED)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      pll_reset_d = (state_d == PLL_RESET) || (state_d == FAILED);
      gt_reset_d  = (state_d == PLL_RESET) || (state_d == WAIT_LOCK) ||
                    (state_d == GT_RESET)  || (state_d == FAILED);
      ready_d     = (state_d == READY);
      error_d     = (state_d == FAILED);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= PLL_RESET;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         gt_reset_q  <= 1'b1;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         gt_reset_q  <= gt_reset_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
      end
   end

   assign bus.pll_reset_out   = pll_reset_q;
   assign bus.gt_reset_out    = gt_reset_q;
   assign bus.user_ready_out  = ready_q;
   assign bus.error_out       = error_q;
   assign bus.retry_count_out = retry_q;

endmodule

// File: tb/tb_gt_reset_controller.sv
// Directed bench for gt_reset_controller: expected outputs and latencies go through a scoreboard queue.
module tb_gt_reset_controller;
   import gt_reset_pkg::*;

   localparam int SIG_PLL = 0;
   localparam int SIG_GT  = 1;
   localparam int SIG_RDY = 2;
   localparam int SIG_ERR = 3;

   logic clk_in = 1'b0;
   logic rst_in;

   gt_reset_controller_if bus ();

   gt_reset_controller #(
      .PLL_RESET_CYCLES    (4),
      .GT_RESET_CYCLES     (4),
      .LOCK_TIMEOUT_CYCLES (32),
      .DONE_TIMEOUT_CYCLES (32),
      .MAX_RETRIES         (2)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       vectors     = 0;
   int       miscompares = 0;
   logic     pll_seen    = 1'b0;

   // Packs {pll, gt, ready, error, retry} into one comparable word.
   function automatic logic [31:0] o(input logic pll, input logic gt, input logic rdy,
                                     input logic err, input logic [2:0] rc);
      return 32'({pll, gt, rdy, err, rc});
   endfunction

   function automatic logic [31:0] outs();
      return 32'({bus.pll_reset_out, bus.gt_reset_out, bus.user_ready_out,
                  bus.error_out, bus.retry_count_out});
   endfunction

   function automatic logic sig(input int idx);
      case (idx)
         SIG_PLL: return bus.pll_reset_out;
         SIG_GT:  return bus.gt_reset_out;
         SIG_RDY: return bus.user_ready_out;
         default: return bus.error_out;
      endcase
   endfunction

   task automatic push_exp(input string tag, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic check(input logic [31:0] obs);
      sb_item_t it;
      it = sb_q.pop_front();
      vectors++;
      assert (obs === it.exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", it.tag, obs, it.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      if (bus.pll_reset_out) pll_seen = 1'b1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Edges until the selected output reaches val; -1 if the budget expires.
   task automatic wait_sig(input int idx, input logic val, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (sig(idx) === val) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic meas(input string tag, input int exp, input int idx, input logic val,
                       input int budget);
      int n;
      push_exp(tag, 32'(exp));
      wait_sig(idx, val, budget, n);
      check(32'(n));
   endtask

   task automatic chk_outs(input string tag, input logic [31:0] exp);
      push_exp(tag, exp);
      check(outs());
   endtask

   initial begin
      int bad;
      rst_in               = 1'b1;
      bus.start_in         = 1'b0;
      bus.pll_lock_in      = 1'b0;
      bus.gt_reset_done_in = 1'b0;
      ticks(8);
      chk_outs("reset_values", o(1, 1, 0, 0, 3'd0));

      // Nominal bring-up
      rst_in = 1'b0;
      meas("nom_pll_width", 4, SIG_PLL, 1'b0, 50);
      ticks(6);
      bus.pll_lock_in = 1'b1;
      meas("nom_lock_to_gt_fall", 10, SIG_GT, 1'b0, 80);
      chk_outs("nom_wait_done", o(0, 0, 0, 0, 3'd0));
      ticks(8);
      bus.gt_reset_done_in = 1'b1;
      meas("nom_done_to_ready", 6, SIG_RDY, 1'b1, 80);
      chk_outs("nom_ready", o(0, 0, 1, 0, 3'd0));

      // Lock loss in READY
      bus.pll_lock_in = 1'b0;
      meas("ll_ready_fall", 6, SIG_RDY, 1'b0, 80);
      chk_outs("ll_pll_reset", o(1, 1, 0, 0, 3'd0));
      meas("ll_pll_width", 4, SIG_PLL, 1'b0, 50);
      bus.pll_lock_in = 1'b1;
      meas("ll_relock_to_ready", 11, SIG_RDY, 1'b1, 80);
      chk_outs("ll_ready_again", o(0, 0, 1, 0, 3'd0));

      // Done times out once, then succeeds
      pll_seen = 1'b0;
      bus.gt_reset_done_in = 1'b0;
      meas("dt_done_loss_gt_rise", 6, SIG_GT, 1'b1, 80);
      meas("dt_gt_width1", 4, SIG_GT, 1'b0, 50);
      meas("dt_timeout", 32, SIG_GT, 1'b1, 80);
      chk_outs("dt_after_timeout", o(0, 1, 0, 0, 3'd1));
      meas("dt_gt_width2", 4, SIG_GT, 1'b0, 50);
      bus.gt_reset_done_in = 1'b1;
      meas("dt_done_to_ready", 6, SIG_RDY, 1'b1, 80);
      chk_outs("dt_ready", o(0, 0, 1, 0, 3'd1));
      push_exp("dt_no_pll_reset", 32'd0);
      check(32'(pll_seen));

      // rst_in mid-WAIT_DONE
      bus.gt_reset_done_in = 1'b0;
      meas("rs_gt_rise", 6, SIG_GT, 1'b1, 80);
      meas("rs_gt_fall", 4, SIG_GT, 1'b0, 50);
      ticks(3);
      rst_in = 1'b1;
      #1;
      chk_outs("rs_async_reset", o(1, 1, 0, 0, 3'd0));
      ticks(3);
      chk_outs("rs_held", o(1, 1, 0, 0, 3'd0));
      rst_in = 1'b0;
      meas("rs_pll_width", 4, SIG_PLL, 1'b0, 50);
      meas("rs_lock_to_gt_fall", 5, SIG_GT, 1'b0, 50);
      bus.gt_reset_done_in = 1'b1;
      meas("rs_done_to_ready", 6, SIG_RDY, 1'b1, 80);
      chk_outs("rs_ready", o(0, 0, 1, 0, 3'd0));

      // Lock never returns: two timeouts then FAILED
      bus.pll_lock_in      = 1'b0;
      bus.gt_reset_done_in = 1'b0;
      meas("ln_ready_fall", 6, SIG_RDY, 1'b0, 80);
      chk_outs("ln_lock_loss_priority", o(1, 1, 0, 0, 3'd0));
      meas("ln_pll_width1", 4, SIG_PLL, 1'b0, 50);
      meas("ln_timeout1", 32, SIG_PLL, 1'b1, 80);
      chk_outs("ln_retry1", o(1, 1, 0, 0, 3'd1));
      meas("ln_pll_width2", 4, SIG_PLL, 1'b0, 50);
      meas("ln_timeout2", 32, SIG_ERR, 1'b1, 80);
      chk_outs("ln_failed", o(1, 1, 0, 1, 3'd2));
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (outs() !== o(1, 1, 0, 1, 3'd2)) bad++;
      end
      push_exp("ln_failed_hold_bad_cycles", 32'd0);
      check(32'(bad));
      bus.start_in = 1'b1;
      tick();
      bus.start_in = 1'b0;
      chk_outs("ln_start_clears", o(1, 1, 0, 0, 3'd0));
      meas("ln_start_pll_width", 4, SIG_PLL, 1'b0, 50);

      // start_in on the lock-timeout cycle wins
      ticks(31);
      chk_outs("st_before_timeout", o(0, 1, 0, 0, 3'd0));
      bus.start_in = 1'b1;
      tick();
      bus.start_in = 1'b0;
      chk_outs("st_start_wins", o(1, 1, 0, 0, 3'd0));
      meas("st_pll_width", 4, SIG_PLL, 1'b0, 50);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gt_reset_controller.md
# gt_reset_controller

Sequences the reset/initialisation of a serial transceiver channel: drives PLL reset and channel reset, waits for the asynchronous PLL-lock and reset-done status to come back, and declares the link ready. Both status inputs cross into `clk_in` through `bit_synchronizer` instances. The controller retries on timeouts, and reports a terminal failure after a bounded number of retries. Sits between the board-level reset/start logic and the transceiver wrapper; `user_ready_out` gates the user datapath.

## Interface
- `PLL_RESET_CYCLES`, 16: cycles `pll_reset_out` is held in PLL_RESET (≥1)
- `GT_RESET_CYCLES`, 16: cycles `gt_reset_out` is held in GT_RESET (≥1)
- `LOCK_TIMEOUT_CYCLES`, 4096: max cycles in WAIT_LOCK (≥2)
- `DONE_TIMEOUT_CYCLES`, 65536: max cycles in WAIT_DONE (≥2)
- `MAX_RETRIES`, 3: timeouts tolerated before FAILED (1..7)
- `clk_in` in 1: sole clock
- `rst_in` in 1: asynchronous, active-high reset
- `start_in` in 1: synchronous pulse; restarts sequence, clears retries
- `pll_lock_in` in 1: asynchronous PLL lock status
- `gt_reset_done_in` in 1: asynchronous channel reset-done status
- `pll_reset_out` out 1: PLL reset, active-high
- `gt_reset_out` out 1: channel reset, active-high
- `user_ready_out` out 1: link ready
- `error_out` out 1: retries exhausted
- `retry_count_out` out 3: timeouts since last rst/start, saturating at 7

## Operation
- Reset values: `pll_reset_out`=1, `gt_reset_out`=1, `user_ready_out`=0, `error_out`=0, `retry_count_out`=0. State after reset is PLL_RESET with the counter at 0.
- The internal status signals `lock_s` and `done_s` come from `bit_synchronizer` instances with INITIALIZE=0.
- One shared cycle counter. It clears on every state entry and is sized for the largest parameter.
- PLL_RESET: pll=1, gt=1. Go to WAIT_LOCK after exactly PLL_RESET_CYCLES cycles.
- WAIT_LOCK: pll=0, gt=1.
  - `lock_s`=1 -> GT_RESET.
  - After LOCK_TIMEOUT_CYCLES cycles without lock: retry++. Go to FAILED if the new count ≥ MAX_RETRIES, else go to PLL_RESET.
- GT_RESET: pll=0, gt=1.
  - After GT_RESET_CYCLES cycles -> WAIT_DONE.
  - `lock_s`=0 -> PLL_RESET.
- WAIT_DONE: pll=0, gt=0.
  - `done_s`=1 -> READY.
  - `lock_s`=0 -> PLL_RESET.
  - After DONE_TIMEOUT_CYCLES cycles: retry++. Go to FAILED if the count ≥ MAX_RETRIES, else go to GT_RESET (PLL is not reset).
- READY: pll=0, gt=0, ready=1.
  - `lock_s`=0 -> PLL_RESET.
  - `done_s`=0 -> GT_RESET.
  - Neither case increments retry.
- FAILED: pll=1, gt=1, ready=0, error=1. Held until `start_in` or `rst_in`.
- Priority in the same cycle: `start_in` > lock loss > done loss/done seen > timeout. `start_in` in any state -> PLL_RESET, retry_count=0, error=0.
- Lock loss never counts as a retry. Only timeouts count.

## Timing
- All outputs are registered and decoded from the next state. They take their new values on the same edge that enters the state.
- Synchronizer latency is 5 `clk_in` edges from an async input change to `lock_s`/`done_s`. Total controller latency is 6 edges from an input change to the state change.
- Reset hold widths are exact: `pll_reset_out` is high for PLL_RESET_CYCLES cycles per PLL_RESET visit. The same applies to GT_RESET.
- Timeout: the state is exited on the LOCK/DONE_TIMEOUT_CYCLES-th cycle after entry. An event on that same cycle wins over the timeout.
- `rst_in` asserted mid-sequence forces the reset values immediately (asynchronously). The sequence restarts from PLL_RESET on the first edge after deassertion. Synchronizer contents are not reset.

## Structure
- Shared package `gt_reset_pkg` holds:
  - the state encodings (PLL_RESET, WAIT_LOCK, GT_RESET, WAIT_DONE, READY, FAILED; 3 bits);
  - SYNC_STAGES=5;
  - the retry-count width.
- Sub-module: `bit_synchronizer`, instantiated twice (lock, done). No other hierarchy.

## Test plan
Bench parameters for all scenarios: PLL_RESET_CYCLES=4, GT_RESET_CYCLES=4, LOCK_TIMEOUT=32, DONE_TIMEOUT=32, MAX_RETRIES=2.

- Nominal bring-up, with lock raised 10 cycles after reset release and done raised 8 cycles after `gt_reset_out` falls:
  - pll high exactly 4 cycles;
  - gt falls 4 cycles after lock_s;
  - ready rises 6 edges after done input;
  - retry=0.
- Lock never asserts -> two 32-cycle WAIT_LOCK windows, retry 1 then 2, then FAILED. error=1 with pll=gt=1 held for 100 cycles. A `start_in` pulse then gives error=0, retry=0, and PLL_RESET.
- Done times out once then succeeds -> retry=1 and gt_reset re-pulses 4 cycles. pll_reset is not reasserted. Ends in READY.
- Lock drops in READY -> ready falls 6 edges later and pll_reset pulses 4 cycles. retry is unchanged. The link recovers to READY.
- `rst_in` asserted mid-WAIT_DONE for 3 cycles -> outputs take their reset values asynchronously that same cycle, then the full sequence restarts.
- `start_in` coincident with the lock-timeout cycle -> PLL_RESET with retry=0 (start wins).
